uart_rx_deframe_fifo: RTL
=========================

Name: uart_rx_deframe_fifo

Overview:
- Downstream stage of the UART-Rx serial-in/parallel-out shift register.
- Takes the 11-bit parallel frame and its received flag (held high for many baud cycles per frame), and captures each frame exactly once.
- Checks the start, stop and parity bits, extracts the 8-bit payload, and buffers it in a first-word-fall-through FIFO with a valid/ready read port.
- Reports sticky parity, framing and overrun status to the core-side UART register block.

Parameters:
- DEPTH, 8: FIFO entries; power of 2, ≥2.
- PARITY_EN, 1: 1 = check bit 9 as parity; 0 = ignore bit 9.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity.
- DROP_BAD, 1: 1 = frames with any error are not written to the FIFO; 0 = they are written anyway.

Ports:
- baud_clk, input, 1: sole clock (same clock as the SIPO stage).
- reset, input, 1: synchronous, active-high reset.
- data_parll, input, 11: frame; [0]=start, [8:1]=data LSB-first, [9]=parity, [10]=stop.
- recieved_flag, input, 1: frame-valid level from the SIPO stage.
- rd_data, output, 8: FIFO head byte.
- rd_valid, output, 1: FIFO non-empty.
- rd_ready, input, 1: consumer accepts the head byte.
- fifo_count, output, $clog2(DEPTH+1): occupancy.
- parity_err, output, 1: sticky; a parity mismatch was seen.
- frame_err, output, 1: sticky; start≠0 or stop≠1 was seen.
- overrun, output, 1: sticky; a good frame arrived while the FIFO was full.
- clr_status, input, 1: single-cycle pulse; clears the three sticky flags.

Behaviour:
- Reset (synchronous, all registers):
  - Pointers and count = 0; rd_valid = 0; rd_data = 8'h00.
  - All sticky flags = 0; capture-stage valid = 0.
  - flag_prev = 1, so a recieved_flag already high when reset deasserts is NOT captured.
- Edge detect:
  - capture = recieved_flag & ~flag_prev.
  - flag_prev <= recieved_flag every cycle.
  - One capture per frame, regardless of how long the flag is held.
- Stage S1, registered on the capture cycle:
  - s1_data <= data_parll[8:1].
  - s1_ferr <= data_parll[0] | ~data_parll[10].
  - s1_perr <= PARITY_EN & ((^data_parll[9:1]) != PARITY_ODD).
  - s1_valid <= capture.
- Stage S2, cycle after capture:
  - bad = s1_ferr | s1_perr.
  - Set the matching sticky flags.
  - Write s1_data to the FIFO if s1_valid & ~(DROP_BAD & bad).
- Latency:
  - Capture sampled at edge N; FIFO write at edge N+1.
  - From an empty FIFO, rd_valid = 1 and rd_data = byte after edge N+1.
- Read handshake:
  - Pop when rd_valid & rd_ready.
  - rd_data is stable while rd_valid=1 and rd_ready=0.
  - rd_ready while empty has no effect.
- Full:
  - Write with no pop in the same cycle: byte discarded, overrun <= 1, count unchanged.
  - Write and pop in the same cycle while full: both succeed, count unchanged, overrun not set.
- Empty: a write with rd_ready=1 in the same cycle does not pop (rd_valid is still 0); count becomes 1.
- Pointers: wrap modulo DEPTH; count ranges 0..DEPTH.
- Sticky flags: a set and clr_status in the same cycle → set wins.
- Errored frame with DROP_BAD=0: the byte is written normally and the error flags are set.
- Back-to-back frames: a capture can occur on consecutive flag rising edges; S1/S2 are fully pipelined with no stall.

Test Plan:
- Reset, then frame 11'h54A (data 8'hA5, even parity 0, stop 1) with the flag high for 16 cycles → exactly one write. rd_valid rises 2 edges after the flag is first sampled. rd_data=8'hA5, count=1, all flags 0. Pop with rd_ready=1 → rd_valid=0.
- Frame 11'h74A (parity bit flipped), DROP_BAD=1 → parity_err=1, count stays 0. clr_status pulse → parity_err=0.
- Frame 11'h14A (stop=0) with DROP_BAD=0 → frame_err=1, rd_data=8'hA5 written.
- Nine good frames 8'h01..8'h09, rd_ready=0, DEPTH=8 → count=8, overrun=1. Drain → rd_data sequence 01..08, then rd_valid=0.
- FIFO full, rd_ready=1 held, new frame 8'h3C → count stays 8, overrun=0, 8'h3C is read last.
- Assert reset while recieved_flag=1 and count=3, release with the flag still high → count=0, rd_valid=0, no capture until the flag falls and rises again.

Source files
------------

// File: rtl/uart_rx_deframe_fifo.sv
// Captures each SIPO frame once on the rising edge of recieved_flag, checks start/stop/parity and queues the payload in a FWFT FIFO.
// Latency: byte readable two edges after the flag is first sampled; a write into a full FIFO without a same-cycle pop is dropped and flags overrun.
module uart_rx_deframe_fifo #(
    parameter int DEPTH      = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0,
    parameter bit DROP_BAD   = 1'b1
) (
    input  logic                         baud_clk,
    input  logic                         reset,
    input  logic [10:0]                  data_parll,
    input  logic                         recieved_flag,
    output logic [7:0]                   rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         parity_err,
    output logic                         frame_err,
    output logic                         overrun,
    input  logic                         clr_status
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic          flag_prev;
    logic          capture;
    logic          s1_valid;
    logic          s1_ferr;
    logic          s1_perr;
    logic [7:0]    s1_data;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          bad;
    logic          wr_req;
    logic          do_wr;
    logic          pop;

    // flag_prev resets high so a flag already asserted out of reset is not taken as a new frame
    assign capture = recieved_flag & ~flag_prev;

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            flag_prev <= 1'b1;
            s1_valid  <= 1'b0;
            s1_data   <= 8'h00;
            s1_ferr   <= 1'b0;
            s1_perr   <= 1'b0;
        end else begin
            flag_prev <= recieved_flag;
            s1_valid  <= capture;
            if (capture) begin
                s1_data <= data_parll[8:1];
                s1_ferr <= data_parll[0] | ~data_parll[10];
                s1_perr <= PARITY_EN & ((^data_parll[9:1]) != PARITY_ODD);
            end
        end
    end

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign bad    = s1_ferr | s1_perr;
    assign wr_req = s1_valid & ~(DROP_BAD & bad);
    assign pop    = ~empty & rd_ready;
    // a pop frees the slot in the same cycle, so full only blocks a write with no pop
    assign do_wr  = wr_req & (~full | pop);

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge baud_clk) begin
        if (do_wr) mem[wr_ptr] <= s1_data;
    end

    // sticky flags: a new event outranks a simultaneous clear
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= (parity_err & ~clr_status) | (s1_valid & s1_perr);
            frame_err  <= (frame_err  & ~clr_status) | (s1_valid & s1_ferr);
            overrun    <= (overrun    & ~clr_status) | (wr_req & full & ~pop);
        end
    end

    assign rd_valid   = ~empty;
    assign rd_data    = empty ? 8'h00 : mem[rd_ptr];
    assign fifo_count = count;

endmodule
